// File: rtl/frv_irq_arbiter.sv
// Platform interrupt arbiter: per-source gateways, priority/threshold selection,
// claim/complete handshake and a small configuration register port.
module frv_irq_arbiter #(
    parameter int unsigned NSRC   = 8,
    parameter int unsigned PRIO_W = 3
) (
    input  logic              g_clk,
    input  logic              g_reset,
    input  logic [NSRC-1:0]   src_irq,
    output logic              ex_pending,
    input  logic              claim_req,
    output logic              claim_ack,
    output logic [4:0]        claim_id,
    input  logic              complete_valid,
    input  logic [4:0]        complete_id,
    input  logic              cfg_wen,
    input  logic              cfg_ren,
    input  logic [5:0]        cfg_addr,
    input  logic [31:0]       cfg_wdata,
    output logic [31:0]       cfg_rdata
);

    typedef enum logic [1:0] {
        GW_IDLE   = 2'd0,
        GW_PEND   = 2'd1,
        GW_FLIGHT = 2'd2
    } gw_state_e;

    gw_state_e         gw_q   [1:NSRC];
    gw_state_e         gw_d   [1:NSRC];
    logic [PRIO_W-1:0] prio_q [1:NSRC];
    logic [PRIO_W-1:0] prio_d [1:NSRC];
    logic [NSRC:1]     en_q, en_d;
    logic [PRIO_W-1:0] thr_q, thr_d;
    logic [4:0]        best_id_q, best_id_d;
    logic              ex_pending_q, ex_pending_d;
    logic              claim_ack_q, claim_ack_d;
    logic [4:0]        claim_id_q, claim_id_d;
    logic [31:0]       cfg_rdata_q, cfg_rdata_d;
    logic [NSRC:1]     pend_map, flight_map;
    logic [PRIO_W-1:0] best_prio;
    logic [31:0]       rd_val;
    logic              unused_wdata;

    assign unused_wdata = ^cfg_wdata;

    // Completion only matches IDs 1..NSRC in FLIGHT, so ID 0 / out-of-range IDs fall out naturally.
    always_comb begin
        for (int unsigned i = 1; i <= NSRC; i++) begin
            gw_d[i] = gw_q[i];
            case (gw_q[i])
                GW_IDLE:   if (src_irq[i-1]) gw_d[i] = GW_PEND;
                GW_PEND:   if (claim_req && best_id_q == 5'(i)) gw_d[i] = GW_FLIGHT;
                GW_FLIGHT: if (complete_valid && complete_id == 5'(i)) gw_d[i] = GW_IDLE;
                default:   gw_d[i] = GW_IDLE;
            endcase
        end
    end

    always_comb begin
        thr_d = thr_q;
        en_d  = en_q;
        for (int unsigned i = 1; i <= NSRC; i++) begin
            prio_d[i] = prio_q[i];
        end
        if (cfg_wen) begin
            if (cfg_addr == 6'h00) thr_d = cfg_wdata[PRIO_W-1:0];
            if (cfg_addr == 6'h01) en_d  = cfg_wdata[NSRC:1];
            for (int unsigned i = 1; i <= NSRC; i++) begin
                if (cfg_addr == 6'(16 + i)) prio_d[i] = cfg_wdata[PRIO_W-1:0];
            end
        end
    end

    // Selection looks at next-state values so the registered best_id matches visible state.
    always_comb begin
        best_id_d = '0;
        best_prio = '0;
        for (int unsigned i = 1; i <= NSRC; i++) begin
            if (gw_d[i] == GW_PEND && en_d[i] && prio_d[i] > thr_d && prio_d[i] > best_prio) begin
                best_id_d = 5'(i);
                best_prio = prio_d[i];
            end
        end
        ex_pending_d = (best_id_d != '0);
    end

    always_comb begin
        for (int unsigned i = 1; i <= NSRC; i++) begin
            pend_map[i]   = (gw_q[i] == GW_PEND);
            flight_map[i] = (gw_q[i] == GW_FLIGHT);
        end
        rd_val = '0;
        case (cfg_addr)
            6'h00:   rd_val = 32'(thr_q);
            6'h01:   rd_val = 32'({en_q, 1'b0});
            6'h02:   rd_val = 32'({pend_map, 1'b0});
            6'h03:   rd_val = 32'({flight_map, 1'b0});
            default: begin
                for (int unsigned i = 1; i <= NSRC; i++) begin
                    if (cfg_addr == 6'(16 + i)) rd_val = 32'(prio_q[i]);
                end
            end
        endcase
        cfg_rdata_d = cfg_ren ? rd_val : cfg_rdata_q;
        claim_ack_d = claim_req;
        claim_id_d  = claim_req ? best_id_q : claim_id_q;
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            for (int unsigned i = 1; i <= NSRC; i++) begin
                gw_q[i]   <= GW_IDLE;
                prio_q[i] <= '0;
            end
            en_q         <= '0;
            thr_q        <= '0;
            best_id_q    <= '0;
            ex_pending_q <= 1'b0;
            claim_ack_q  <= 1'b0;
            claim_id_q   <= '0;
            cfg_rdata_q  <= '0;
        end else begin
            for (int unsigned i = 1; i <= NSRC; i++) begin
                gw_q[i]   <= gw_d[i];
                prio_q[i] <= prio_d[i];
            end
            en_q         <= en_d;
            thr_q        <= thr_d;
            best_id_q    <= best_id_d;
            ex_pending_q <= ex_pending_d;
            claim_ack_q  <= claim_ack_d;
            claim_id_q   <= claim_id_d;
            cfg_rdata_q  <= cfg_rdata_d;
        end
    end

    assign ex_pending = ex_pending_q;
    assign claim_ack  = claim_ack_q;
    assign claim_id   = claim_id_q;
    assign cfg_rdata  = cfg_rdata_q;

endmodule
